// File: rtl/sequence_detector_mealy_param.sv
// Runtime-programmable Mealy serial-pattern detector with overlap control.
// Optional saturating match counter built when MATCH_CNT_EN is defined.
module sequence_detector_mealy_param #(
    parameter int               PAT_W       = 4,
    parameter int               LEN_W       = 3,
    parameter logic [PAT_W-1:0] RST_PATTERN = 4'b1101,
    parameter int               RST_LEN     = 4,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             overlap,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] fill;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [PAT_W-1:0] cand;
    logic             pat_eq;
    logic             fill_ok;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (int'(l) > PAT_W)
            return LEN_W'(PAT_W);
        return l;
    endfunction

    function automatic logic [LEN_W-1:0] sat_fill(input logic [LEN_W-1:0] f);
        if (int'(f) >= PAT_W)
            return LEN_W'(PAT_W);
        return f + 1'b1;
    endfunction

    generate
        if (PAT_W > 1) begin : g_shift
            assign cand = {hist[PAT_W-2:0], in_bit};
        end else begin : g_single
            assign cand = in_bit;
        end
    endgenerate

    // Only the low len_q bits of the candidate take part in the comparison.
    always_comb begin
        pat_eq = 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(len_q) && cand[i] != pat_q[i])
                pat_eq = 1'b0;
        end
        fill_ok = (int'(fill) + 1) >= int'(len_q);
        match   = reset_n & in_valid & ~cfg_we & (len_q != '0) & fill_ok & pat_eq;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist  <= '0;
            fill  <= '0;
            pat_q <= RST_PATTERN;
            len_q <= LEN_W'(RST_LEN);
        end else if (cfg_we) begin
            hist  <= '0;
            fill  <= '0;
            pat_q <= cfg_pattern;
            len_q <= clamp_len(cfg_len);
        end else if (in_valid) begin
            hist <= cand;
            if (match && !overlap)
                fill <= '0;
            else
                fill <= sat_fill(fill);
        end
    end

`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}})
            return c;
        return c + 1'b1;
    endfunction

    // A clear coincident with a match leaves that match counted.
    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (cnt_clr)
            cnt_q <= match ? CNT_W'(1) : '0;
        else if (match)
            cnt_q <= sat_inc(cnt_q);
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule
